// File: rtl/tmr_scrub_counter.sv
// tmr_scrub_counter: triplicated self-scrubbing up-counter with bitwise majority vote and upset tracking.
// Defining TMR_SCRUB_FAULT_INJECT_EN adds the INJ port for per-copy fault injection.
module tmr_scrub_counter #(
  parameter int WIDTH = 8,
  parameter int ERRW = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ERR,
  output logic [2:0]       ERRSEL,
  output logic [ERRW-1:0]  ERRCNT,
  input  logic             ERRCLR
`ifdef TMR_SCRUB_FAULT_INJECT_EN
  ,
  input  logic [2:0]       INJ
`endif
);
  logic [WIDTH-1:0] c0_q, c1_q, c2_q, c0_d, c1_d, c2_d, v, nxt;
  logic [2:0] mm, errsel_q, errsel_d;
  logic err_q, err_d;
  logic [ERRW-1:0] errcnt_q, errcnt_d;
  always_comb begin
    v = (c0_q & c1_q) | (c1_q & c2_q) | (c0_q & c2_q);
    mm = {c2_q != v, c1_q != v, c0_q != v};
    nxt = LD ? D : (EN ? v + WIDTH'(1) : v);
`ifdef TMR_SCRUB_FAULT_INJECT_EN
    c0_d = nxt ^ {WIDTH{INJ[0]}};
    c1_d = nxt ^ {WIDTH{INJ[1]}};
    c2_d = nxt ^ {WIDTH{INJ[2]}};
`else
    c0_d = nxt;
    c1_d = nxt;
    c2_d = nxt;
`endif
    err_d = |mm;
    errsel_d = mm;
    errcnt_d = ERRCLR ? '0 : ((|mm && !(&errcnt_q)) ? errcnt_q + ERRW'(1) : errcnt_q);
  end
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      c0_q <= RESET_VALUE;
      c1_q <= RESET_VALUE;
      c2_q <= RESET_VALUE;
      err_q <= 1'b0;
      errsel_q <= '0;
      errcnt_q <= '0;
    end else begin
      c0_q <= c0_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      err_q <= err_d;
      errsel_q <= errsel_d;
      errcnt_q <= errcnt_d;
    end
  end
  assign Q = v;
  assign CO = EN & ~LD & (&v);
  assign ERR = err_q;
  assign ERRSEL = errsel_q;
  assign ERRCNT = errcnt_q;
endmodule

// File: doc/tmr_scrub_counter.md
Name: tmr_scrub_counter

Overview:
- Parametrised, triplicated, self-scrubbing up-counter with bitwise majority voting.
- Next generation of the plain DFCNQD1/FA1D0/HA1D0/MAOI222 counter slices used in TMRG test netlists.
- Adds width generalisation, load, carry-out, per-copy mismatch detection, a saturating upset counter and optional fault injection.
- Instantiated wherever a radiation-tolerant counter (timers, BX counters) is needed without running TMRG on the surrounding logic.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- ERRW, 4, width of upset counter ERRCNT (>=1).
- RESET_VALUE, 0, value loaded into all three copies on reset (WIDTH bits).

Ports:
- CP  input  1  clock, rising edge.
- CD  input  1  asynchronous active-high reset.
- EN  input  1  count enable.
- LD  input  1  synchronous load, priority over EN.
- D  input  WIDTH  load value.
- Q  output  WIDTH  voted counter value.
- CO  output  1  carry out, combinational wrap indication.
- ERR  output  1  registered one-cycle mismatch pulse.
- ERRSEL  output  3  registered per-copy mismatch flags; bit i = copy i.
- ERRCNT  output  ERRW  saturating count of cycles with any mismatch.
- ERRCLR  input  1  synchronous clear of ERRCNT.

Behaviour:
- Reset (CD=1, async):
  - c0, c1, c2 = RESET_VALUE.
  - ERR = 0, ERRSEL = 0, ERRCNT = 0.
  - Q = RESET_VALUE; CO = 0 unless EN=1 and RESET_VALUE = all ones.
- Release is asynchronous; the first rising CP edge with CD=0 is an active edge.
- Voting:
  - v = bitwise majority (c0&c1 | c1&c2 | c0&c2).
  - Q = v, purely combinational from the copy registers; no added latency.
- Next state, applied identically to every copy (scrubbing):
  - LD=1 -> D.
  - else EN=1 -> v+1 mod 2^WIDTH.
  - else -> v (refresh; a single-copy upset is corrected at the next edge even when idle).
- Count latency: Q changes one edge after EN=1 is sampled. LD with EN: LD wins, no increment.
- Wrap: v = 2^WIDTH-1 with EN=1, LD=0 -> next v = 0.
- CO = EN & ~LD & (v == 2^WIDTH-1), combinational.
- Mismatch:
  - mm[i] = (ci != v), evaluated on the pre-edge state.
  - At each edge: ERRSEL <= mm and ERR <= |mm.
  - The upset is therefore reported in the cycle after it becomes visible, i.e. the same cycle the scrub has corrected it.
- Multi-bit, multi-copy upsets:
  - Voting is per bit, so different copies can lose different bits.
  - ERRSEL may then show more than one bit set; Q follows the bitwise majority.
- ERRCNT:
  - ERRCLR=1 -> 0; clear wins over a simultaneous increment.
  - else |mm=1 and ERRCNT < 2^ERRW-1 -> +1.
  - saturates at all ones; never wraps.
- Reset mid-count: all state returns to reset values immediately, irrespective of CP.
- No X propagation from D when LD=0.

Optional Feature:
- Macro: TMR_SCRUB_FAULT_INJECT_EN.
- Defined:
  - Adds input port INJ, width 3, after ERRCLR.
  - When INJ[i]=1 at an edge, copy i loads the bitwise inverse of its computed next value.
  - Other copies load normally.
  - Lets benches and in-system tests create upsets without force statements.
- Undefined:
  - Port INJ is absent; all copies always load the computed next value.
  - Benches inject upsets by forcing or depositing the copy registers.

Test Plan:
- Reset then count: CD pulse, RESET_VALUE=0, WIDTH=8, EN=1 for 5 edges -> Q=5, ERR=0, ERRCNT=0; CO=0 throughout.
- Wrap and load:
  - LD=1, D=8'hFE, then EN=1 for 2 edges -> Q=8'hFE then 8'hFF; CO=1 while Q=8'hFF.
  - Next edge -> Q=8'h00, CO=0.
  - LD=1 with EN=1, D=8'h10 -> Q=8'h10, no increment.
- Single-copy upset while idle:
  - Q=8'h10, EN=0; corrupt c1 to 8'h55 -> Q stays 8'h10.
  - Next edge: ERR=1, ERRSEL=3'b010, ERRCNT=1, c1=8'h10.
  - Following edge: ERR=0.
- Bitwise multi-copy upset: with v=8'h00, c0=8'h01 and c2=8'h80 -> Q=8'h00; next edge ERRSEL=3'b101, ERRCNT +1.
- Saturation and clear:
  - ERRW=4, inject an upset on 20 consecutive edges -> ERRCNT stops at 15.
  - ERRCLR=1 together with a new upset -> ERRCNT=0.
- Async reset mid-operation: CD asserted between edges while counting at Q=8'h37 with ERRCNT=3 -> Q=RESET_VALUE, ERRCNT=0, ERR=0 immediately, without a CP edge.
